beat_scene_scheduler: RTL and testbench
=======================================

// Module: beat_scene_scheduler
// PURPOSE
//  Beat-locked scheduler for the visualiser's draw layers. Takes tempo from the tempo finder, free-runs a
//  beat clock on the audio-sample strobe, and emits beatHit plus beat/bar/scene position. From a scene table
//  it drives dancer_en and motionType into the motion manager, so dancer choreography changes on musical bars.
// PARAMETERS
//  MIN_TICS        12000  smallest accepted tics_per_beat (240 BPM @ 48 kHz)
//  MAX_TICS        96000  largest accepted tics_per_beat (30 BPM @ 48 kHz)
//  BEATS_PER_BAR   4      beats per bar, 1..16
//  BARS_PER_SCENE  4      bars per scene, 1..16
//  TIMEOUT_BEATS   16     beats with no valid tempo update before LOST
// PORTS
//  clk             in   1   system clock
//  reset           in   1   asynchronous, active-high reset
//  enable          in   1   scheduler run enable; low forces IDLE
//  aud_strobe      in   1   1-cycle pulse per audio sample, synchronous to clk
//  tics_per_beat   in   32  tempo period in audio samples
//  tics_valid      in   1   1-cycle qualifier for tics_per_beat
//  tap             in   1   1-cycle tap-tempo/resync pulse (debounced upstream)
//  dancer_mask     in   4   user mask ANDed into dancer_en
//  beatHit         out  1   1-cycle beat pulse
//  beat_in_bar     out  4   0..BEATS_PER_BAR-1
//  scene           out  3   current scene index 0..NUM_SCENES-1
//  dancer_en       out  4   scene_table[scene].dancers & dancer_mask
//  motionType      out  2   scene_table[scene].motion
//  tempo_lost      out  1   high in LOST
//  period_err      out  1   1-cycle pulse: tics_valid with out-of-range value
// BEHAVIOUR
//  Reset: all outputs 0; period=0, shadow=0, tick_cnt=0, timeout_cnt=0, state=IDLE.
//  States: IDLE -> RUN on in-range tics_valid (or tap with TAP feature, period=MAX_TICS) while enable=1.
//   RUN -> LOST when timeout_cnt reaches TIMEOUT_BEATS; LOST -> RUN on in-range tics_valid.
//   Any state -> IDLE in the cycle after enable=0; counters, scene, beat_in_bar clear; outputs 0.
//  Tempo load: in-range tics_valid writes shadow, clears timeout_cnt. In IDLE, period=shadow immediately;
//   in RUN/LOST, period<=shadow only at the next beat boundary (no mid-beat period change).
//   Out-of-range: ignored, period_err pulses the next cycle. Range inclusive [MIN_TICS, MAX_TICS].
//  Beat clock (RUN/LOST): tick_cnt increments on aud_strobe; when aud_strobe and tick_cnt==period-1,
//   tick_cnt<=0 and beat boundary occurs. beatHit registered: asserts exactly 1 cycle after boundary cycle.
//   If period shrinks below tick_cnt+1 at load, wrap at next aud_strobe (compare >=, not ==).
//  Position: each beat: beat_in_bar++ wrapping at BEATS_PER_BAR; on wrap bar_cnt++ wrapping at
//   BARS_PER_SCENE; on that wrap scene++ wrapping at NUM_SCENES. timeout_cnt++ per beat, saturating.
//  dancer_en/motionType registered from scene (1-cycle after scene update); forced 0 in IDLE.
//  LOST: free-wheels on last period; tempo_lost=1; scene still advances.
// CONFIGURATION
//  BEAT_SCHED_TAP_EN defined: tap forces a beat boundary that cycle (tick_cnt<=0, beatHit next cycle,
//   beat_in_bar<=0, bar_cnt<=0 without advancing scene); tap coincident with natural wrap -> one beatHit.
//   Tap in IDLE with no valid period enters RUN with period=MAX_TICS.
//  Not defined: tap port present but ignored; IDLE exits only via valid tempo.
// STRUCTURE
//  Package screen_pkg: scene_t {dancers[3:0], motion[1:0]}, NUM_SCENES=8, SCENE_TABLE constant,
//   sched_state_e {IDLE,RUN,LOST}, AUD_RATE=48000.
//  Sub-module beat_tick_counter: period shadow/load, tick_cnt, boundary pulse; top holds FSM + position.
// TESTING
//  1 tics_per_beat=12000 valid, strobe every cycle -> beatHit every 12000 cycles; beat_in_bar 0,1,2,3,0.
//  2 16 beats at 12000 -> scene 0->1 at beat 16; dancer_en = SCENE_TABLE[1].dancers & 4'hF one cycle later.
//  3 mid-beat (tick_cnt=5000) load 24000 -> current beat still ends at 12000; next beat 24000 long.
//  4 tics_per_beat=5000 valid -> period_err 1 pulse, period unchanged; 16 beats no update -> tempo_lost=1.
//  5 tap at tick_cnt=3000 (TAP_EN) -> beatHit next cycle, beat_in_bar=0; tap on wrap cycle -> single beatHit.
//  6 async reset / enable=0 mid-beat -> all outputs 0, state IDLE; re-enable needs new tics_valid.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and constants for the beat/scene scheduler: scene table, FSM states, tempo range helper.
package screen_pkg;

  localparam int unsigned AUD_RATE   = 48000;
  localparam int unsigned NUM_SCENES = 8;
  localparam int unsigned SCENE_W    = 3;
  localparam int unsigned TICS_W     = 32;

  typedef struct packed {
    logic [3:0] dancers;
    logic [1:0] motion;
  } scene_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } sched_state_e;

  // Choreography per scene: dancer set grows, then alternates patterns.
  localparam scene_t SCENE_TABLE [NUM_SCENES] = '{
    '{dancers: 4'b0001, motion: 2'd0},
    '{dancers: 4'b0011, motion: 2'd1},
    '{dancers: 4'b0111, motion: 2'd2},
    '{dancers: 4'b1111, motion: 2'd3},
    '{dancers: 4'b1010, motion: 2'd1},
    '{dancers: 4'b0101, motion: 2'd2},
    '{dancers: 4'b1100, motion: 2'd3},
    '{dancers: 4'b1001, motion: 2'd0}
  };

  function automatic logic tics_in_range(input logic [TICS_W-1:0] tics,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (tics >= TICS_W'(lo)) && (tics <= TICS_W'(hi));
  endfunction

endpackage

// File: rtl/beat_tick_counter.sv
// Beat clock: tempo shadow/period registers and the audio-sample tick counter that marks beat boundaries.
module beat_tick_counter
  import screen_pkg::*;
#(
  parameter int unsigned MAX_TICS = 96000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_run,
  input  logic              i_aud_strobe,
  input  logic [TICS_W-1:0] i_tics,
  input  logic              i_shadow_we,
  input  logic              i_load_now,
  input  logic              i_tap_start,
  input  logic              i_tap_beat,
  output logic              o_boundary_c
);

  logic [TICS_W-1:0] r_shadow;
  logic [TICS_W-1:0] r_period;
  logic [TICS_W-1:0] r_tick_cnt;
  logic              w_boundary;

  // >= so a period shortened mid-beat still wraps on the next strobe.
  assign w_boundary   = i_run && (i_tap_beat ||
                        (i_aud_strobe && (r_tick_cnt >= (r_period - TICS_W'(1)))));
  assign o_boundary_c = w_boundary;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow   <= '0;
      r_period   <= '0;
      r_tick_cnt <= '0;
    end else if (i_clear) begin
      r_shadow   <= '0;
      r_period   <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (i_shadow_we) r_shadow <= i_tics;

      // Period only changes on entry from IDLE or at a beat boundary.
      if (i_load_now) begin
        r_period <= i_tics;
      end else if (i_tap_start) begin
        r_period <= TICS_W'(MAX_TICS);
        r_shadow <= TICS_W'(MAX_TICS);
      end else if (w_boundary) begin
        r_period <= r_shadow;
      end

      if (w_boundary)                  r_tick_cnt <= '0;
      else if (i_run && i_aud_strobe)  r_tick_cnt <= r_tick_cnt + TICS_W'(1);
    end
  end

endmodule

// File: rtl/beat_scene_scheduler.sv
// Beat-locked draw-layer scheduler: run/lost FSM, beat/bar/scene position and scene-table outputs.
// Define BEAT_SCHED_TAP_EN to make the tap input force beat resync and start from IDLE.
module beat_scene_scheduler
  import screen_pkg::*;
#(
  parameter int unsigned MIN_TICS       = 12000,
  parameter int unsigned MAX_TICS       = 96000,
  parameter int unsigned BEATS_PER_BAR  = 4,
  parameter int unsigned BARS_PER_SCENE = 4,
  parameter int unsigned TIMEOUT_BEATS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              aud_strobe,
  input  logic [TICS_W-1:0] tics_per_beat,
  input  logic              tics_valid,
  input  logic              tap,
  input  logic [3:0]        dancer_mask,
  output logic              beatHit,
  output logic [3:0]        beat_in_bar,
  output logic [SCENE_W-1:0] scene,
  output logic [3:0]        dancer_en,
  output logic [1:0]        motionType,
  output logic              tempo_lost,
  output logic              period_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_BEATS + 1);

  sched_state_e       r_state;
  logic [TO_W-1:0]    r_timeout_cnt;
  logic [3:0]         r_beat_in_bar;
  logic [3:0]         r_bar_cnt;
  logic [SCENE_W-1:0] r_scene;
  logic               r_beat_hit;
  logic [3:0]         r_dancer_en;
  logic [1:0]         r_motion;
  logic               r_tempo_lost;
  logic               r_period_err;

  logic w_in_range;
  logic w_valid_ok;
  logic w_tap;
  logic w_run;
  logic w_idle_en;
  logic w_boundary;

`ifdef BEAT_SCHED_TAP_EN
  assign w_tap = tap;
`else
  assign w_tap = tap & 1'b0;
`endif

  assign w_in_range = tics_in_range(tics_per_beat, MIN_TICS, MAX_TICS);
  assign w_valid_ok = tics_valid && w_in_range;
  assign w_run      = (r_state != IDLE);
  assign w_idle_en  = enable && (r_state == IDLE);

  beat_tick_counter #(
    .MAX_TICS (MAX_TICS)
  ) u_tick (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_clear      (~enable),
    .i_run        (w_run),
    .i_aud_strobe (aud_strobe),
    .i_tics       (tics_per_beat),
    .i_shadow_we  (enable && w_valid_ok),
    .i_load_now   (w_idle_en && w_valid_ok),
    .i_tap_start  (w_idle_en && w_tap && !w_valid_ok),
    .i_tap_beat   (w_tap),
    .o_boundary_c (w_boundary)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_timeout_cnt <= '0;
      r_beat_in_bar <= '0;
      r_bar_cnt     <= '0;
      r_scene       <= '0;
      r_beat_hit    <= 1'b0;
      r_dancer_en   <= '0;
      r_motion      <= '0;
      r_tempo_lost  <= 1'b0;
      r_period_err  <= 1'b0;
    end else if (!enable) begin
      r_state       <= IDLE;
      r_timeout_cnt <= '0;
      r_beat_in_bar <= '0;
      r_bar_cnt     <= '0;
      r_scene       <= '0;
      r_beat_hit    <= 1'b0;
      r_dancer_en   <= '0;
      r_motion      <= '0;
      r_tempo_lost  <= 1'b0;
      r_period_err  <= 1'b0;
    end else begin
      r_period_err <= tics_valid && !w_in_range;
      r_beat_hit   <= w_boundary;

      case (r_state)
        IDLE: begin
          if (w_valid_ok || w_tap) r_state <= RUN;
        end
        RUN: begin
          if (!w_valid_ok && (r_timeout_cnt == TO_W'(TIMEOUT_BEATS))) begin
            r_state      <= LOST;
            r_tempo_lost <= 1'b1;
          end
        end
        LOST: begin
          if (w_valid_ok) begin
            r_state      <= RUN;
            r_tempo_lost <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_valid_ok)
        r_timeout_cnt <= '0;
      else if (w_boundary && (r_timeout_cnt != TO_W'(TIMEOUT_BEATS)))
        r_timeout_cnt <= r_timeout_cnt + TO_W'(1);

      // A tap resyncs to the start of a bar but keeps the current scene.
      if (w_boundary) begin
        if (w_tap) begin
          r_beat_in_bar <= '0;
          r_bar_cnt     <= '0;
        end else if (r_beat_in_bar == 4'(BEATS_PER_BAR - 1)) begin
          r_beat_in_bar <= '0;
          if (r_bar_cnt == 4'(BARS_PER_SCENE - 1)) begin
            r_bar_cnt <= '0;
            r_scene   <= (r_scene == SCENE_W'(NUM_SCENES - 1)) ? '0 : r_scene + SCENE_W'(1);
          end else begin
            r_bar_cnt <= r_bar_cnt + 4'd1;
          end
        end else begin
          r_beat_in_bar <= r_beat_in_bar + 4'd1;
        end
      end

      if (w_run) begin
        r_dancer_en <= SCENE_TABLE[r_scene].dancers & dancer_mask;
        r_motion    <= SCENE_TABLE[r_scene].motion;
      end else begin
        r_dancer_en <= '0;
        r_motion    <= '0;
      end
    end
  end

  assign beatHit     = r_beat_hit;
  assign beat_in_bar = r_beat_in_bar;
  assign scene       = r_scene;
  assign dancer_en   = r_dancer_en;
  assign motionType  = r_motion;
  assign tempo_lost  = r_tempo_lost;
  assign period_err  = r_period_err;

endmodule

// File: tb/tb_beat_scene_scheduler.sv
// Directed bench for beat_scene_scheduler with a scaled tempo range (12..96 tics) to keep runs short.
module tb_beat_scene_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        aud_strobe;
  logic [31:0] tics_per_beat;
  logic        tics_valid;
  logic        tap;
  logic [3:0]  dancer_mask;
  logic        beatHit;
  logic [3:0]  beat_in_bar;
  logic [2:0]  scene;
  logic [3:0]  dancer_en;
  logic [1:0]  motionType;
  logic        tempo_lost;
  logic        period_err;

  int checks = 0;
  int errors = 0;

  beat_scene_scheduler #(
    .MIN_TICS       (12),
    .MAX_TICS       (96),
    .BEATS_PER_BAR  (4),
    .BARS_PER_SCENE (4),
    .TIMEOUT_BEATS  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .aud_strobe    (aud_strobe),
    .tics_per_beat (tics_per_beat),
    .tics_valid    (tics_valid),
    .tap           (tap),
    .dancer_mask   (dancer_mask),
    .beatHit       (beatHit),
    .beat_in_bar   (beat_in_bar),
    .scene         (scene),
    .dancer_en     (dancer_en),
    .motionType    (motionType),
    .tempo_lost    (tempo_lost),
    .period_err    (period_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_beat(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!beatHit && n < 300);
  endtask

  task automatic count_hits(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      cyc(1);
      if (beatHit) hits++;
    end
  endtask

  task automatic restart();
    reset = 1'b1; enable = 1'b0; tics_valid = 1'b0; tap = 1'b0;
    aud_strobe = 1'b1; tics_per_beat = '0; dancer_mask = 4'hF;
    cyc(2);
    reset = 1'b0; enable = 1'b1;
    cyc(1);
  endtask

  task automatic start(input logic [31:0] t);
    tics_per_beat = t; tics_valid = 1'b1;
    cyc(1);
    tics_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    restart();
    outs = {beatHit, beat_in_bar, scene, dancer_en, motionType, tempo_lost, period_err};
    checks++;
    if (outs !== 17'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
  endtask

  task automatic test_beat_clock();
    int n;
    restart();
    start(32'd12);
    for (int k = 1; k <= 5; k++) begin
      wait_beat(n);
      checks++;
      if (n != 12 || beat_in_bar !== 4'(k % 4)) begin
        errors++; $display("FAIL beat_clock beat%0d got len %0d bib %0d want 12 %0d", k, n, beat_in_bar, k % 4);
      end
    end
    cyc(1);
    checks++;
    if (beatHit !== 1'b0 || dancer_en !== 4'b0001 || motionType !== 2'd0) begin
      errors++; $display("FAIL beat_clock_pulse got hit %b den %b mt %0d want 0 0001 0", beatHit, dancer_en, motionType);
    end
  endtask

  task automatic test_scene();
    int n;
    restart();
    dancer_mask = 4'b1011;
    start(32'd12);
    for (int k = 1; k <= 15; k++) wait_beat(n);
    checks++;
    if (scene !== 3'd0) begin errors++; $display("FAIL scene_before got %0d want 0", scene); end
    wait_beat(n);
    checks++;
    if (scene !== 3'd1 || dancer_en !== 4'b0001) begin
      errors++; $display("FAIL scene_change got scene %0d den %b want 1 0001", scene, dancer_en);
    end
    cyc(1);
    checks++;
    if (dancer_en !== 4'b0011 || motionType !== 2'd1) begin
      errors++; $display("FAIL scene_dancers got den %b mt %0d want 0011 1", dancer_en, motionType);
    end
  endtask

  task automatic test_midbeat_load();
    int n;
    restart();
    start(32'd12);
    cyc(5);
    tics_per_beat = 32'd24; tics_valid = 1'b1;
    cyc(1);
    tics_valid = 1'b0;
    wait_beat(n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL midbeat_current got %0d want 6", n); end
    wait_beat(n);
    checks++;
    if (n != 24) begin errors++; $display("FAIL midbeat_next got %0d want 24", n); end
    wait_beat(n);
    checks++;
    if (n != 24 || period_err !== 1'b0) begin
      errors++; $display("FAIL midbeat_steady got %0d perr %b want 24 0", n, period_err);
    end
  endtask

  task automatic test_range_timeout();
    int n;
    int hits;
    restart();
    tics_per_beat = 32'd11; tics_valid = 1'b1;
    cyc(1);
    tics_valid = 1'b0;
    checks++;
    if (period_err !== 1'b1) begin errors++; $display("FAIL err_below got %b want 1", period_err); end
    count_hits(30, hits);
    checks++;
    if (hits != 0 || dancer_en !== 4'd0) begin
      errors++; $display("FAIL err_idle got hits %0d den %b want 0 0", hits, dancer_en);
    end
    start(32'd96);
    wait_beat(n);
    checks++;
    if (n != 96) begin errors++; $display("FAIL max_period got %0d want 96", n); end

    restart();
    start(32'd12);
    cyc(3);
    tics_per_beat = 32'd97; tics_valid = 1'b1;
    cyc(1);
    tics_valid = 1'b0;
    checks++;
    if (period_err !== 1'b1) begin errors++; $display("FAIL err_above got %b want 1", period_err); end
    cyc(1);
    checks++;
    if (period_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", period_err); end
    wait_beat(n);
    checks++;
    if (n != 7) begin errors++; $display("FAIL err_period_kept got %0d want 7", n); end
    for (int k = 2; k <= 15; k++) wait_beat(n);
    checks++;
    if (tempo_lost !== 1'b0) begin errors++; $display("FAIL lost_early got %b want 0", tempo_lost); end
    wait_beat(n);
    cyc(1);
    checks++;
    if (tempo_lost !== 1'b1) begin errors++; $display("FAIL lost_set got %b want 1", tempo_lost); end
    wait_beat(n);
    checks++;
    if (n != 11) begin errors++; $display("FAIL lost_freewheel got %0d want 11", n); end
    tics_per_beat = 32'd12; tics_valid = 1'b1;
    cyc(1);
    tics_valid = 1'b0;
    checks++;
    if (tempo_lost !== 1'b0) begin errors++; $display("FAIL lost_recover got %b want 0", tempo_lost); end
  endtask

  task automatic test_tap();
    int n;
    int hits;
    restart();
    start(32'd12);
    wait_beat(n);
    wait_beat(n);
    cyc(3);
    tap = 1'b1;
    cyc(1);
    tap = 1'b0;
`ifdef BEAT_SCHED_TAP_EN
    checks++;
    if (beatHit !== 1'b1 || beat_in_bar !== 4'd0) begin
      errors++; $display("FAIL tap_resync got hit %b bib %0d want 1 0", beatHit, beat_in_bar);
    end
    wait_beat(n);
    checks++;
    if (n != 12 || beat_in_bar !== 4'd1) begin
      errors++; $display("FAIL tap_next got len %0d bib %0d want 12 1", n, beat_in_bar);
    end
    cyc(11);
    tap = 1'b1;
    cyc(1);
    tap = 1'b0;
    checks++;
    if (beatHit !== 1'b1 || beat_in_bar !== 4'd0 || scene !== 3'd0) begin
      errors++; $display("FAIL tap_wrap got hit %b bib %0d sc %0d want 1 0 0", beatHit, beat_in_bar, scene);
    end
    count_hits(11, hits);
    checks++;
    if (hits != 0) begin errors++; $display("FAIL tap_single got %0d hits want 0", hits); end
    restart();
    tap = 1'b1;
    cyc(1);
    tap = 1'b0;
    wait_beat(n);
    checks++;
    if (n != 96) begin errors++; $display("FAIL tap_idle_start got %0d want 96", n); end
`else
    checks++;
    if (beatHit !== 1'b0 || beat_in_bar !== 4'd2) begin
      errors++; $display("FAIL tap_ignored got hit %b bib %0d want 0 2", beatHit, beat_in_bar);
    end
    wait_beat(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL tap_ignored_len got %0d want 8", n); end
    restart();
    tap = 1'b1;
    cyc(1);
    tap = 1'b0;
    count_hits(120, hits);
    checks++;
    if (hits != 0 || dancer_en !== 4'd0) begin
      errors++; $display("FAIL tap_idle_ignored got hits %0d den %b want 0 0", hits, dancer_en);
    end
`endif
  endtask

  task automatic test_disable_reset();
    int n;
    int hits;
    logic [16:0] outs;
    restart();
    start(32'd12);
    for (int k = 1; k <= 5; k++) wait_beat(n);
    cyc(4);
    enable = 1'b0;
    cyc(1);
    outs = {beatHit, beat_in_bar, scene, dancer_en, motionType, tempo_lost, period_err};
    checks++;
    if (outs !== 17'd0) begin errors++; $display("FAIL disable_outputs got %h want 0", outs); end
    enable = 1'b1;
    count_hits(30, hits);
    checks++;
    if (hits != 0 || dancer_en !== 4'd0) begin
      errors++; $display("FAIL reenable_idle got hits %0d den %b want 0 0", hits, dancer_en);
    end
    start(32'd12);
    wait_beat(n);
    checks++;
    if (n != 12 || beat_in_bar !== 4'd1) begin
      errors++; $display("FAIL reenable_run got len %0d bib %0d want 12 1", n, beat_in_bar);
    end
    cyc(3);
    #2 reset = 1'b1;
    #1;
    outs = {beatHit, beat_in_bar, scene, dancer_en, motionType, tempo_lost, period_err};
    checks++;
    if (outs !== 17'd0) begin errors++; $display("FAIL async_reset got %h want 0", outs); end
    @(posedge clk);
    #1 reset = 1'b0;
    count_hits(30, hits);
    checks++;
    if (hits != 0) begin errors++; $display("FAIL reset_idle got %0d hits want 0", hits); end
  endtask

  initial begin
    test_reset();
    test_beat_clock();
    test_scene();
    test_midbeat_load();
    test_range_timeout();
    test_tap();
    test_disable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
